regfile_sb: RTL and testbench

Parametrised, scoreboarded successor to the single-cycle datapath register file. It provides two asynchronous read ports and one synchronous write port over DATA_W x 2^ADDR_W entries, with entry 0 hardwired to zero. It adds a hardware clear sequencer after reset and a per-entry busy scoreboard for multi-cycle/pipelined producers. It sits between decode (read/scoreboard query) and writeback in the pipelined datapath.

---
 rtl/regfile_sb.sv | 94 +++++++++
 tb/tb_regfile_sb.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Scoreboarded register file: 2 async read ports, 1 sync write port, post-reset clear sequencer.
// Optional same-cycle write-through on reads when REGFILE_BYPASS_EN is defined.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              ready,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] wr_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [ADDR_W-1:0] rr1_in,
    input  logic [ADDR_W-1:0] rr2_in,
    output logic [DATA_W-1:0] rdata1_out,
    output logic [DATA_W-1:0] rdata2_out,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic              rr1_busy,
    output logic              rr2_busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              wr_en;
    logic              set_en;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            ready   <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt == RUN);
            if (state == CLEAR)
                clr_cnt <= clr_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == CLEAR && clr_cnt == ADDR_W'(DEPTH - 1))
            state_nxt = RUN;
        wr_en  = (state == RUN) && regwrite && (wr_in != '0);
        set_en = (state == RUN) && sb_set && (sb_set_addr != '0);
    end

    // Storage has no reset; the clear sequencer zeroes it and reads are gated until RUN.
    always_ff @(posedge clock) begin
        if (state == CLEAR)
            mem[clr_cnt] <= '0;
        else if (wr_en)
            mem[wr_in] <= write_data_in;
    end

    // Set is applied after the writeback clear so a same-address set wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy <= '0;
        end else begin
            if (wr_en)
                busy[wr_in] <= 1'b0;
            if (set_en)
                busy[sb_set_addr] <= 1'b1;
        end
    end

    always_comb begin
        rdata1_out = '0;
        rdata2_out = '0;
        if (state == RUN && rr1_in != '0)
            rdata1_out = mem[rr1_in];
        if (state == RUN && rr2_in != '0)
            rdata2_out = mem[rr2_in];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_in == rr1_in)
            rdata1_out = write_data_in;
        if (wr_en && wr_in == rr2_in)
            rdata2_out = write_data_in;
`endif
    end

    always_comb begin
        rr1_busy = (state == RUN) && (rr1_in != '0) && busy[rr1_in];
        rr2_busy = (state == RUN) && (rr2_in != '0) && busy[rr2_in];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with an array-based reference model checked every negedge.
module tb_regfile_sb;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ready;
    logic        regwrite = 1'b0;
    logic [4:0]  wr_in = '0;
    logic [31:0] write_data_in = '0;
    logic [4:0]  rr1_in = '0;
    logic [4:0]  rr2_in = '0;
    logic [31:0] rdata1_out, rdata2_out;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_set_addr = '0;
    logic        rr1_busy, rr2_busy;

    int errors = 0;
    int checks = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset_n(reset_n), .ready(ready),
        .regwrite(regwrite), .wr_in(wr_in), .write_data_in(write_data_in),
        .rr1_in(rr1_in), .rr2_in(rr2_in),
        .rdata1_out(rdata1_out), .rdata2_out(rdata2_out),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr),
        .rr1_busy(rr1_busy), .rr2_busy(rr2_busy)
    );

    always #5 clock = ~clock;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Reference model: contents unknown until the clear pass has visited them.
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_run = 1'b0;
    int          m_cnt = 0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_run = 1'b0;
            m_cnt = 0;
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (!m_run) begin
            m_mem[m_cnt] = 32'h0;
            m_cnt = m_cnt + 1;
            if (m_cnt == 32) m_run = 1'b1;
        end else begin
            if (regwrite && wr_in != 0) begin
                m_mem[wr_in] = write_data_in;
                m_busy[wr_in] = 1'b0;
            end
            if (sb_set && sb_set_addr != 0) m_busy[sb_set_addr] = 1'b1;
        end
    end

    function automatic logic [31:0] exp_rdata(input logic [4:0] a);
        if (!m_run || a == 0) return 32'h0;
        if (BYPASS && regwrite && wr_in == a) return write_data_in;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (!m_run || a == 0) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("m_ready", 64'(ready), 64'(m_run));
        chk("m_rdata1", 64'(rdata1_out), 64'(exp_rdata(rr1_in)));
        chk("m_rdata2", 64'(rdata2_out), 64'(exp_rdata(rr2_in)));
        chk("m_busy1", 64'(rr1_busy), 64'(exp_busy(rr1_in)));
        chk("m_busy2", 64'(rr2_busy), 64'(exp_busy(rr2_in)));
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int edges = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (ready === 1'b1) begin
                edges = n;
                break;
            end
        end
        chk(name, 64'(edges), 64'd32);
    endtask

    initial begin
        rr1_in = 5'd4;
        rr2_in = 5'd6;
        #2;
        chk("rst_ready", 64'(ready), 64'd0);
        chk("rst_rdata1", 64'(rdata1_out), 64'd0);
        chk("rst_busy2", 64'(rr2_busy), 64'd0);

        // Release mid-cycle, with writes and scoreboard sets pending during the clear pass.
        #11;
        reset_n       = 1'b1;
        regwrite      = 1'b1;
        wr_in         = 5'd4;
        write_data_in = 32'hFFFF_FFFF;
        sb_set        = 1'b1;
        sb_set_addr   = 5'd6;
        wait_ready("clear_edges");
        regwrite = 1'b0;
        sb_set   = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rr1_in = 5'(i);
            rr2_in = 5'(31 - i);
            #0.1;
            if (rdata1_out !== 32'h0 || rdata2_out !== 32'h0 || rr1_busy || rr2_busy)
                chk("sweep_zero", {rdata1_out, rdata2_out}, 64'h0);
        end
        rr1_in = 5'd4;
        rr2_in = 5'd6;
        #0.1;
        chk("clear_ignored_wr", 64'(rdata1_out), 64'd0);
        chk("clear_ignored_sb", 64'(rr2_busy), 64'd0);

        tick();
        regwrite = 1'b1; wr_in = 5'd5; write_data_in = 32'hDEAD_BEEF;
        tick();
        regwrite = 1'b0; rr1_in = 5'd5; rr2_in = 5'd5;
        #1;
        chk("r5_port1", 64'(rdata1_out), 64'hDEAD_BEEF);
        chk("r5_port2", 64'(rdata2_out), 64'hDEAD_BEEF);

        regwrite = 1'b1; wr_in = 5'd0; write_data_in = 32'h1234;
        tick();
        regwrite = 1'b0; rr1_in = 5'd0;
        #1;
        chk("r0_zero", 64'(rdata1_out), 64'd0);

        rr1_in = 5'd7;
        regwrite = 1'b1; wr_in = 5'd7; write_data_in = 32'hA5A5_A5A5;
        #1;
        chk("r7_same_cycle", 64'(rdata1_out), BYPASS ? 64'hA5A5_A5A5 : 64'd0);
        tick();
        regwrite = 1'b0;
        #1;
        chk("r7_next_cycle", 64'(rdata1_out), 64'hA5A5_A5A5);

        sb_set = 1'b1; sb_set_addr = 5'd9; rr1_in = 5'd9;
        #1;
        chk("r9_busy_pre", 64'(rr1_busy), 64'd0);
        tick();
        sb_set = 1'b0;
        #1;
        chk("r9_busy_set", 64'(rr1_busy), 64'd1);
        regwrite = 1'b1; wr_in = 5'd9; write_data_in = 32'h1;
        #1;
        chk("r9_busy_not_bypassed", 64'(rr1_busy), 64'd1);
        tick();
        regwrite = 1'b0;
        #1;
        chk("r9_busy_wb_clear", 64'(rr1_busy), 64'd0);
        regwrite = 1'b1; write_data_in = 32'h2; sb_set = 1'b1;
        tick();
        regwrite = 1'b0; sb_set = 1'b0;
        #1;
        chk("r9_set_wins", 64'(rr1_busy), 64'd1);
        chk("r9_data", 64'(rdata1_out), 64'd2);

        regwrite = 1'b1; wr_in = 5'd3; write_data_in = 32'h55;
        tick();
        regwrite = 1'b0; rr1_in = 5'd3; rr2_in = 5'd9;
        #1;
        chk("r3_written", 64'(rdata1_out), 64'h55);
        reset_n = 1'b0;
        #1;
        chk("async_ready", 64'(ready), 64'd0);
        chk("async_rdata1", 64'(rdata1_out), 64'd0);
        chk("async_busy2", 64'(rr2_busy), 64'd0);
        @(negedge clock);
        #3;
        reset_n = 1'b1;
        wait_ready("reclear_edges");
        #1;
        chk("r3_after_reset", 64'(rdata1_out), 64'd0);
        chk("r9_busy_after_reset", 64'(rr2_busy), 64'd0);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
